// File: rtl/ucsbece154b_branch_predictor_pkg.sv
// ucsbece154b_branch_predictor_pkg: shared BTB/GHR widths, PHT reset value and 2-bit counter encodings
package ucsbece154b_branch_predictor_pkg;
  localparam int BTB_ENTRIES = 32;
  localparam int GHR_BITS = 5;
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;
  localparam ctr_t PHT_RESET = CTR_WNT;
endpackage

// File: rtl/ucsbece154b_sat_counter2.sv
// ucsbece154b_sat_counter2: 2-bit saturating up/down counter, async reset to weakly not-taken
//   clk, reset_n (async, active-low); en: count this cycle; up: +1 when set, -1 otherwise; q: counter state
module ucsbece154b_sat_counter2
  import ucsbece154b_branch_predictor_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic up,
  output ctr_t q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= PHT_RESET;
    else if (en) q <= up ? (q == CTR_ST ? CTR_ST : ctr_t'(q + 2'd1))
                         : (q == CTR_SNT ? CTR_SNT : ctr_t'(q - 2'd1));
endmodule

// File: rtl/ucsbece154b_branch_predictor.sv
// ucsbece154b_branch_predictor: fetch-stage direct-mapped BTB plus gshare PHT, trained from Execute
//   Fetch:   PCF_i -> BranchTakenF_o, BTBtargetF_o, PHTindexF_o (combinational lookup)
//   Execute: PCE_i, BranchE_i, JumpE_i, BranchTakenE_i, BranchTargetE_i, PHTindexE_i (posedge training)
//   clk, reset_n (async, active-low)
module ucsbece154b_branch_predictor
  import ucsbece154b_branch_predictor_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = BTB_ENTRIES,
  parameter int NUM_GHR_BITS = GHR_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             PCF_i,
  output logic                    BranchTakenF_o,
  output logic [31:0]             BTBtargetF_o,
  output logic [NUM_GHR_BITS-1:0] PHTindexF_o,
  input  logic [31:0]             PCE_i,
  input  logic                    BranchE_i,
  input  logic                    JumpE_i,
  input  logic                    BranchTakenE_i,
  input  logic [31:0]             BranchTargetE_i,
  input  logic [NUM_GHR_BITS-1:0] PHTindexE_i
);
  localparam int IDXW = $clog2(NUM_BTB_ENTRIES);
  localparam int TAGW = 30 - IDXW;
  localparam int PHT_N = 2 ** NUM_GHR_BITS;
  if (NUM_GHR_BITS > 30 || IDXW > 30) begin : g_bad_width
    $error("branch predictor: NUM_GHR_BITS and index width must not exceed 30");
  end
  logic [NUM_BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]            tag_q    [NUM_BTB_ENTRIES];
  logic [31:0]                target_q [NUM_BTB_ENTRIES];
  logic [NUM_BTB_ENTRIES-1:0] jump_q;
  logic [NUM_BTB_ENTRIES-1:0] branch_q;
  logic [NUM_GHR_BITS-1:0]    ghr_q;
  ctr_t                       pht [PHT_N];
  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit, train;
  logic            unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF_i[1:0], PCE_i[1:0]};
  assign idx_f = PCF_i[2 +: IDXW];
  assign tag_f = PCF_i[31 -: TAGW];
  assign idx_e = PCE_i[2 +: IDXW];
  assign tag_e = PCE_i[31 -: TAGW];
  assign train = BranchE_i | JumpE_i;
  assign hit = valid_q[idx_f] & (tag_q[idx_f] == tag_f);
  assign PHTindexF_o = PCF_i[2 +: NUM_GHR_BITS] ^ ghr_q;
  assign BranchTakenF_o = hit & (jump_q[idx_f] | (branch_q[idx_f] & pht[PHTindexF_o][1]));
  assign BTBtargetF_o = hit ? target_q[idx_f] : 32'b0;
  // Only the valid bits need reset; stale tag/target/type contents are masked by them.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) valid_q <= '0;
    else if (train) valid_q[idx_e] <= 1'b1;
  always_ff @(posedge clk)
    if (train) begin
      tag_q[idx_e] <= tag_e;
      target_q[idx_e] <= BranchTargetE_i;
      jump_q[idx_e] <= JumpE_i;
      branch_q[idx_e] <= BranchE_i;
    end
  // History is non-speculative: shifted only when a conditional branch resolves in Execute.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ghr_q <= '0;
    else if (BranchE_i) ghr_q <= NUM_GHR_BITS'({ghr_q, BranchTakenE_i});
  for (genvar g = 0; g < PHT_N; g++) begin : g_pht
    ucsbece154b_sat_counter2 u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (BranchE_i && (PHTindexE_i == NUM_GHR_BITS'(g))),
      .up      (BranchTakenE_i),
      .q       (pht[g])
    );
  end
endmodule
